// File: rtl/mm_stim_pkg.sv
// Shared constants and types for the memory-mapped stimulus/response port.
// Status and clear bit positions are counted down from the data-word MSB.
package mm_stim_pkg;

  localparam int STS_UDF   = 0;
  localparam int STS_FULL  = 1;
  localparam int STS_EMPTY = 2;

  localparam int CLR_UDF = 0;
  localparam int CLR_OVF = 1;

  // Capture entry layout for the default configuration (4 channels, 16-bit data).
  localparam int CAP_CH_W   = 2;
  localparam int CAP_DATA_W = 16;

  typedef struct packed {
    logic [CAP_CH_W-1:0]   ch;
    logic [CAP_DATA_W-1:0] data;
  } cap_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head. A pop on empty is ignored, and a push
// while full is accepted only if a pop frees a slot on the same edge.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/mm_stim_port.sv
// Memory-mapped stimulus/response port: per-channel read FIFOs preloaded by the host and
// drained by CPU reads, plus one tagged capture FIFO filled by CPU writes.
module mm_stim_port
  import mm_stim_pkg::*;
#(
  parameter int                DATA_W        = 16,
  parameter int                ADDR_W        = 16,
  parameter int                NUM_CH        = 4,
  parameter int                DEPTH         = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 16'hC000,
  parameter logic [DATA_W-1:0] DEFAULT_RDATA = 16'hAAAA,
  localparam int               CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              mm_re,
  input  logic              mm_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [CH_W-1:0]   ld_ch,
  input  logic [DATA_W-1:0] ld_data,
  output logic              cap_valid,
  input  logic              cap_ready,
  output logic [CH_W-1:0]   cap_ch,
  output logic [DATA_W-1:0] cap_data,
  output logic              cap_ovf
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } cap_word_t;

  logic [NUM_CH-1:0] stim_push, stim_pop, stim_full, stim_empty;
  logic [DATA_W-1:0] stim_head  [NUM_CH];
  logic [CNT_W-1:0]  stim_count [NUM_CH];

  logic [DATA_W-1:0] rdata_q, rdata_d, sts_word;
  logic [NUM_CH-1:0] udf_q, udf_d;
  logic              cap_ovf_q, cap_ovf_d;

  logic      hit, ch_ok, acc, ld_ok;
  logic      data_rd, data_wr, sts_wr;
  logic      cap_full, cap_empty;
  cap_word_t cap_din, cap_head;
  logic [CNT_W-1:0] unused_cap_count;
  logic [CH_W-1:0]  ch;

  // A simultaneous read and write performs only the read.
  assign hit     = (addr[ADDR_W-1:CH_W+1] == BASE_ADDR[ADDR_W-1:CH_W+1]);
  assign ch      = addr[CH_W:1];
  assign ch_ok   = (NUM_CH > 1) || (ch == '0);
  assign ld_ok   = (NUM_CH > 1) || (ld_ch == '0);
  assign acc     = hit && ch_ok;
  assign data_rd = mm_re && acc && !addr[0];
  assign data_wr = mm_we && !mm_re && acc && !addr[0];
  assign sts_wr  = mm_we && !mm_re && acc && addr[0];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      stim_pop[i] = data_rd && (ch == CH_W'(i)) && !stim_empty[i];
      udf_d[i]    = (udf_q[i] && !(sts_wr && (ch == CH_W'(i)) && wdata[DATA_W-1-CLR_UDF]))
                 || (data_rd && (ch == CH_W'(i)) && stim_empty[i]);
    end
  end

  // A CPU pop on the loaded channel frees a slot in time for this cycle's host push.
  assign ld_ready = ld_ok && (!stim_full[ld_ch] || stim_pop[ld_ch]);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      stim_push[i] = ld_valid && ld_ready && (ld_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_stim
    sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (stim_push[g]),
      .pop   (stim_pop[g]),
      .din   (ld_data),
      .full  (stim_full[g]),
      .empty (stim_empty[g]),
      .count (stim_count[g]),
      .head  (stim_head[g])
    );
  end

  assign cap_din = '{ch: ch, data: wdata};

  sync_fifo #(.WIDTH(CH_W + DATA_W), .DEPTH(DEPTH)) u_cap_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (data_wr),
    .pop   (cap_ready),
    .din   (cap_din),
    .full  (cap_full),
    .empty (cap_empty),
    .count (unused_cap_count),
    .head  (cap_head)
  );

  assign cap_valid = !cap_empty;
  assign cap_ch    = cap_head.ch;
  assign cap_data  = cap_head.data;

  always_comb begin
    sts_word                        = '0;
    sts_word[DATA_W-1-STS_UDF]      = udf_q[ch];
    sts_word[DATA_W-1-STS_FULL]     = stim_full[ch];
    sts_word[DATA_W-1-STS_EMPTY]    = stim_empty[ch];
    sts_word[CNT_W-1:0]             = stim_count[ch];

    rdata_d = rdata_q;
    if (mm_re) begin
      if (!acc)                rdata_d = '0;
      else if (addr[0])        rdata_d = sts_word;
      else if (stim_empty[ch]) rdata_d = DEFAULT_RDATA;
      else                     rdata_d = stim_head[ch];
    end

    // A full capture FIFO only absorbs a write when the host pops on the same edge.
    cap_ovf_d = (cap_ovf_q && !(sts_wr && wdata[DATA_W-1-CLR_OVF]))
             || (data_wr && cap_full && !cap_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q   <= DEFAULT_RDATA;
      udf_q     <= '0;
      cap_ovf_q <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      udf_q     <= udf_d;
      cap_ovf_q <= cap_ovf_d;
    end
  end

  assign rdata   = rdata_q;
  assign cap_ovf = cap_ovf_q;

endmodule

// File: tb/tb_mm_stim_port.sv
// Directed bench for mm_stim_port: expected read data and capture entries are queued
// when stimulus is driven and compared when the port produces them.
module tb_mm_stim_port;
  import mm_stim_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic        mm_re, mm_we;
  logic [15:0] wdata, rdata;
  logic        ld_valid, ld_ready;
  logic [1:0]  ld_ch;
  logic [15:0] ld_data;
  logic        cap_valid, cap_ready, cap_ovf;
  logic [1:0]  cap_ch;
  logic [15:0] cap_data;

  int total = 0;
  int bad   = 0;

  logic [15:0] rd_q  [$];
  cap_entry_t  cap_q [$];

  always #5 clk = ~clk;

  mm_stim_port dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .mm_re     (mm_re),
    .mm_we     (mm_we),
    .wdata     (wdata),
    .rdata     (rdata),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_ch     (ld_ch),
    .ld_data   (ld_data),
    .cap_valid (cap_valid),
    .cap_ready (cap_ready),
    .cap_ch    (cap_ch),
    .cap_data  (cap_data),
    .cap_ovf   (cap_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
    @(negedge clk);
    addr  = a;
    mm_re = 1'b1;
    rd_q.push_back(exp);
    @(posedge clk); #1;
    mm_re = 1'b0;
    check(tag, rdata, rd_q.pop_front());
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    mm_we = 1'b1;
    if (!a[0] && cap_q.size() < 8) cap_q.push_back('{ch: a[2:1], data: d});
    @(posedge clk); #1;
    mm_we = 1'b0;
  endtask

  task automatic host_ld(input logic [1:0] c, input logic [15:0] d);
    @(negedge clk);
    ld_ch    = c;
    ld_data  = d;
    ld_valid = 1'b1;
    #1 check("ld_ready_on_load", ld_ready, 1'b1);
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  task automatic cap_take(input string tag);
    cap_entry_t e;
    @(negedge clk);
    cap_ready = 1'b1;
    #1;
    e = cap_q.pop_front();
    check({tag, "_valid"}, cap_valid, 1'b1);
    check({tag, "_ch"}, cap_ch, e.ch);
    check({tag, "_data"}, cap_data, e.data);
    @(posedge clk); #1;
    cap_ready = 1'b0;
  endtask

  initial begin
    cap_entry_t e;
    rst = 1'b1; addr = '0; mm_re = 0; mm_we = 0; wdata = '0;
    ld_valid = 0; ld_ch = '0; ld_data = '0; cap_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 16'hAAAA);
    check("rst_cap_valid", cap_valid, 1'b0);
    check("rst_ld_ready", ld_ready, 1'b1);
    check("rst_cap_ovf", cap_ovf, 1'b0);
    @(negedge clk) rst = 1'b0;

    // Underflow on an empty channel, then its status.
    cpu_rd(16'hC000, 16'hAAAA, "ch0_underflow");
    cpu_rd(16'hC001, 16'hA000, "ch0_status_udf");
    cpu_rd(16'h1000, 16'h0000, "unmapped_read");

    // Ordered drain of channel 2, underflow, sticky clear.
    host_ld(2'd2, 16'h0001);
    host_ld(2'd2, 16'h0002);
    host_ld(2'd2, 16'h0003);
    cpu_rd(16'hC005, 16'h0003, "ch2_status_cnt3");
    cpu_rd(16'hC004, 16'h0001, "ch2_rd1");
    cpu_rd(16'hC004, 16'h0002, "ch2_rd2");
    cpu_rd(16'hC004, 16'h0003, "ch2_rd3");
    cpu_rd(16'hC004, 16'hAAAA, "ch2_rd4_udf");
    cpu_rd(16'hC005, 16'hA000, "ch2_status_udf");
    cpu_wr(16'hC005, 16'h8000);
    cpu_rd(16'hC005, 16'h2000, "ch2_status_cleared");

    // Fill channel 1; ready drops for that channel only.
    for (int i = 0; i < 8; i++) host_ld(2'd1, 16'h0010 + 16'(i));
    @(negedge clk);
    ld_ch = 2'd1;
    #1 check("ld_ready_ch1_full", ld_ready, 1'b0);
    ld_ch = 2'd0;
    #1 check("ld_ready_ch0", ld_ready, 1'b1);
    cpu_rd(16'hC003, 16'h4008, "ch1_status_full");

    // CPU pop and host push on the full channel in the same cycle.
    @(negedge clk);
    ld_ch = 2'd1; ld_data = 16'h0099; ld_valid = 1'b1;
    addr = 16'hC002; mm_re = 1'b1;
    rd_q.push_back(16'h0010);
    #1 check("ld_ready_full_with_pop", ld_ready, 1'b1);
    @(posedge clk); #1;
    ld_valid = 1'b0; mm_re = 1'b0;
    check("ch1_pop_push_rd", rdata, rd_q.pop_front());
    cpu_rd(16'hC003, 16'h4008, "ch1_count_still8");
    for (int i = 1; i < 8; i++) cpu_rd(16'hC002, 16'h0010 + 16'(i), "ch1_drain");
    cpu_rd(16'hC002, 16'h0099, "ch1_drain_last");

    // Read and write together: the read happens, the write is not captured.
    @(negedge clk);
    addr = 16'hC002; wdata = 16'hDEAD; mm_re = 1'b1; mm_we = 1'b1;
    rd_q.push_back(16'hAAAA);
    @(posedge clk); #1;
    mm_re = 1'b0; mm_we = 1'b0;
    check("re_we_read", rdata, rd_q.pop_front());
    check("re_we_no_capture", cap_valid, 1'b0);

    // Push and pop on an empty channel in the same cycle: underflow, push lands.
    @(negedge clk);
    ld_ch = 2'd3; ld_data = 16'h0055; ld_valid = 1'b1;
    addr = 16'hC006; mm_re = 1'b1;
    rd_q.push_back(16'hAAAA);
    @(posedge clk); #1;
    ld_valid = 1'b0; mm_re = 1'b0;
    check("ch3_empty_pushpop_rd", rdata, rd_q.pop_front());
    cpu_rd(16'hC007, 16'h8001, "ch3_status_udf_cnt1");
    cpu_rd(16'hC006, 16'h0055, "ch3_rd_landed");

    // Capture ordering and channel tags.
    cpu_wr(16'hC006, 16'h1234);
    cpu_wr(16'hC000, 16'h5678);
    cap_take("cap_first");
    cap_take("cap_second");
    check("cap_empty_after", cap_valid, 1'b0);

    // Overflow: ninth write dropped, sticky flag, then cleared.
    for (int i = 0; i < 9; i++) cpu_wr(16'hC000, 16'h0100 + 16'(i));
    check("cap_ovf_set", cap_ovf, 1'b1);
    cpu_wr(16'hC003, 16'h4000);
    check("cap_ovf_cleared", cap_ovf, 1'b0);

    // Full capture FIFO with simultaneous pop and push: push accepted, no overflow.
    @(negedge clk);
    cap_ready = 1'b1;
    addr = 16'hC004; wdata = 16'hBEEF; mm_we = 1'b1;
    #1;
    e = cap_q.pop_front();
    check("cap_fullpop_data", cap_data, e.data);
    cap_q.push_back('{ch: 2'd2, data: 16'hBEEF});
    @(posedge clk); #1;
    cap_ready = 1'b0; mm_we = 1'b0;
    check("cap_fullpop_no_ovf", cap_ovf, 1'b0);
    for (int i = 0; i < 8; i++) cap_take("cap_drain");
    check("cap_drained", cap_valid, 1'b0);

    // Reset mid-burst with channel 0 holding data and a capture pending.
    cpu_wr(16'hC000, 16'h7777);
    for (int i = 0; i < 5; i++) host_ld(2'd0, 16'h0A00 + 16'(i));
    cpu_rd(16'hC000, 16'h0A00, "ch0_pre_reset_rd");
    @(negedge clk);
    ld_ch = 2'd0; ld_data = 16'h0BBB; ld_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("midrst_rdata", rdata, 16'hAAAA);
    check("midrst_cap_valid", cap_valid, 1'b0);
    rd_q.delete();
    cap_q.delete();
    ld_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    cpu_rd(16'hC001, 16'h2000, "ch0_status_after_rst");
    cpu_rd(16'hC000, 16'hAAAA, "ch0_empty_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
